// File: rtl/inverse_park_pipe.sv
//==============================================================================
// Module   : inverse_park_pipe
// Function : Three-stage streaming inverse Park transform (D,Q -> alpha,beta)
//            with round-half-up products, valid/ready flow control and a
//            per-sample channel tag. Define INV_PARK_SAT_EN to clip results
//            and report sat; otherwise results wrap and sat is tied low.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module inverse_park_pipe #(
    parameter int D_WIDTH   = 19,
    parameter int Q_BITS    = 15,
    parameter int TAG_WIDTH = 2
) (
    input  logic                        clk,
    input  logic                        rstb,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [TAG_WIDTH-1:0]        in_tag,
    input  logic signed [D_WIDTH-1:0]   D,
    input  logic signed [D_WIDTH-1:0]   Q,
    input  logic signed [D_WIDTH-1:0]   sin,
    input  logic signed [D_WIDTH-1:0]   cos,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [TAG_WIDTH-1:0]        out_tag,
    output logic signed [D_WIDTH-1:0]   alpha,
    output logic signed [D_WIDTH-1:0]   beta,
    output logic                        sat
);

    localparam int c_PROD_W  = 2 * D_WIDTH;
    localparam int c_SUM_W   = 2 * D_WIDTH + 1;
    localparam int c_SHIFT_W = c_SUM_W - Q_BITS;

`ifdef INV_PARK_SAT_EN
    // Keep every bit above the binary point so the clip can see overflow.
    localparam int c_S2_W = c_SHIFT_W;
`else
    // Wrapping only needs the low D_WIDTH bits of the shifted sum.
    localparam int c_S2_W = D_WIDTH;
`endif

    localparam logic signed [c_SUM_W-1:0] c_RND = c_SUM_W'(1) <<< (Q_BITS - 1);

    logic w_en;

    // S1: full-precision products
    logic                         r_s1_valid;
    logic [TAG_WIDTH-1:0]         r_s1_tag;
    logic signed [c_PROD_W-1:0]   r_p_dc;
    logic signed [c_PROD_W-1:0]   r_p_qs;
    logic signed [c_PROD_W-1:0]   r_p_ds;
    logic signed [c_PROD_W-1:0]   r_p_qc;

    // S2: rounded and shifted sums
    logic                         r_s2_valid;
    logic [TAG_WIDTH-1:0]         r_s2_tag;
    logic signed [c_S2_W-1:0]     r_s2_a;
    logic signed [c_S2_W-1:0]     r_s2_b;

    logic signed [c_SUM_W-1:0]    w_ext_dc;
    logic signed [c_SUM_W-1:0]    w_ext_qs;
    logic signed [c_SUM_W-1:0]    w_ext_ds;
    logic signed [c_SUM_W-1:0]    w_ext_qc;

    logic signed [D_WIDTH-1:0]    w_alpha_nxt;
    logic signed [D_WIDTH-1:0]    w_beta_nxt;

    // The whole pipe advances together; nothing moves while the output is stalled.
    assign w_en     = !out_valid || out_ready;
    assign in_ready = w_en;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_s1_valid <= 1'b0;
            r_s1_tag   <= '0;
            r_p_dc     <= '0;
            r_p_qs     <= '0;
            r_p_ds     <= '0;
            r_p_qc     <= '0;
        end else if (w_en) begin
            r_s1_valid <= in_valid;
            r_s1_tag   <= in_tag;
            r_p_dc     <= c_PROD_W'(D) * c_PROD_W'(cos);
            r_p_qs     <= c_PROD_W'(Q) * c_PROD_W'(sin);
            r_p_ds     <= c_PROD_W'(D) * c_PROD_W'(sin);
            r_p_qc     <= c_PROD_W'(Q) * c_PROD_W'(cos);
        end
    end

    assign w_ext_dc = c_SUM_W'(r_p_dc);
    assign w_ext_qs = c_SUM_W'(r_p_qs);
    assign w_ext_ds = c_SUM_W'(r_p_ds);
    assign w_ext_qc = c_SUM_W'(r_p_qc);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_s2_valid <= 1'b0;
            r_s2_tag   <= '0;
            r_s2_a     <= '0;
            r_s2_b     <= '0;
        end else if (w_en) begin
            r_s2_valid <= r_s1_valid;
            r_s2_tag   <= r_s1_tag;
            r_s2_a     <= c_S2_W'((w_ext_dc - w_ext_qs + c_RND) >>> Q_BITS);
            r_s2_b     <= c_S2_W'((w_ext_ds + w_ext_qc + c_RND) >>> Q_BITS);
        end
    end

`ifdef INV_PARK_SAT_EN
    localparam logic signed [D_WIDTH-1:0] c_OUT_MAX = {1'b0, {(D_WIDTH-1){1'b1}}};
    localparam logic signed [D_WIDTH-1:0] c_OUT_MIN = {1'b1, {(D_WIDTH-1){1'b0}}};
    localparam logic signed [c_S2_W-1:0]  c_S2_MAX  = c_S2_W'(c_OUT_MAX);
    localparam logic signed [c_S2_W-1:0]  c_S2_MIN  = c_S2_W'(c_OUT_MIN);

    logic w_clip_a;
    logic w_clip_b;

    always_comb begin
        w_alpha_nxt = D_WIDTH'(r_s2_a);
        w_clip_a    = 1'b0;
        if (r_s2_a > c_S2_MAX) begin
            w_alpha_nxt = c_OUT_MAX;
            w_clip_a    = 1'b1;
        end else if (r_s2_a < c_S2_MIN) begin
            w_alpha_nxt = c_OUT_MIN;
            w_clip_a    = 1'b1;
        end
    end

    always_comb begin
        w_beta_nxt = D_WIDTH'(r_s2_b);
        w_clip_b   = 1'b0;
        if (r_s2_b > c_S2_MAX) begin
            w_beta_nxt = c_OUT_MAX;
            w_clip_b   = 1'b1;
        end else if (r_s2_b < c_S2_MIN) begin
            w_beta_nxt = c_OUT_MIN;
            w_clip_b   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            sat <= 1'b0;
        end else if (w_en) begin
            sat <= w_clip_a || w_clip_b;
        end
    end
`else
    assign w_alpha_nxt = r_s2_a;
    assign w_beta_nxt  = r_s2_b;
    assign sat         = 1'b0;
`endif

    // S3: output registers
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            out_valid <= 1'b0;
            out_tag   <= '0;
            alpha     <= '0;
            beta      <= '0;
        end else if (w_en) begin
            out_valid <= r_s2_valid;
            out_tag   <= r_s2_tag;
            alpha     <= w_alpha_nxt;
            beta      <= w_beta_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_inverse_park_pipe.sv
//==============================================================================
// Module   : tb_inverse_park_pipe
// Function : Scoreboard bench for inverse_park_pipe (honours INV_PARK_SAT_EN).
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_inverse_park_pipe;

    localparam int W  = 19;
    localparam int QB = 15;
    localparam int TW = 2;

    logic                 clk = 1'b0;
    logic                 rstb;
    logic                 in_valid;
    logic                 in_ready;
    logic [TW-1:0]        in_tag;
    logic signed [W-1:0]  D, Q, sin, cos;
    logic                 out_valid;
    logic                 out_ready;
    logic [TW-1:0]        out_tag;
    logic signed [W-1:0]  alpha, beta;
    logic                 sat;

    always #5 clk = ~clk;

    inverse_park_pipe #(.D_WIDTH(W), .Q_BITS(QB), .TAG_WIDTH(TW)) dut (
        .clk(clk), .rstb(rstb),
        .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag),
        .D(D), .Q(Q), .sin(sin), .cos(cos),
        .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
        .alpha(alpha), .beta(beta), .sat(sat)
    );

    typedef struct {
        logic [TW-1:0] tag;
        longint        a;
        longint        b;
        bit            s;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n_out = 0;
    int   first_out = -1;
    int   last_out = -1;
    bit   last_in_x = 1'b0;

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic longint fit(input longint v, output bit clipped);
        longint lim;
        longint m;
        lim     = longint'(1) << (W - 1);
        clipped = 1'b0;
        m       = v;
`ifdef INV_PARK_SAT_EN
        if (v > lim - 1) begin
            m = lim - 1;
            clipped = 1'b1;
        end else if (v < -lim) begin
            m = -lim;
            clipped = 1'b1;
        end
`else
        m = v & ((longint'(1) << W) - 1);
        if (m >= lim) m = m - (longint'(1) << W);
`endif
        return m;
    endfunction

    function automatic exp_t model(input logic [TW-1:0] t, input longint d, input longint q,
                                   input longint s, input longint c);
        exp_t   e;
        bit     ca;
        bit     cb;
        longint rnd;
        rnd   = longint'(1) << (QB - 1);
        e.tag = t;
        e.a   = fit((d * c - q * s + rnd) >>> QB, ca);
        e.b   = fit((d * s + q * c + rnd) >>> QB, cb);
        e.s   = ca | cb;
        return e;
    endfunction

    // One clock: check and account for transfers just before the edge, then step.
    task automatic cycle();
        exp_t e;
        #4;
        chk("in_ready", longint'(in_ready), longint'(!(out_valid && !out_ready)));
        if (out_valid) begin
            chk("sb_nonempty", longint'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb[0];
                chk("out_tag", longint'(out_tag), longint'(e.tag));
                chk("alpha", longint'(alpha), e.a);
                chk("beta", longint'(beta), e.b);
                chk("sat", longint'(sat), longint'(e.s));
                if (out_ready) void'(sb.pop_front());
            end
            if (out_ready) begin
                n_out++;
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
            end
        end
        last_in_x = in_valid && in_ready;
        if (last_in_x)
            sb.push_back(model(in_tag, longint'(D), longint'(Q), longint'(sin), longint'(cos)));
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [TW-1:0] t, input int d, input int q, input int s, input int c);
        int n;
        in_tag   = t;
        D        = W'(d);
        Q        = W'(q);
        sin      = W'(s);
        cos      = W'(c);
        in_valid = 1'b1;
        n        = 0;
        do begin
            cycle();
            n++;
        end while (!last_in_x && n < 100);
        if (!last_in_x) chk("send_timeout", n, 0);
        in_valid = 1'b0;
    endtask

    // Edges from acceptance (acceptance edge counts as 1) until out_valid.
    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 20) begin
            cycle();
            lat++;
        end
    endtask

    function automatic int rnd_data();
        return $urandom_range(0, 524287) - 262144;
    endfunction

    function automatic int rnd_trig();
        return $urandom_range(0, 65534) - 32767;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n0;
        int sent;
        rstb = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_tag = '0; D = '0; Q = '0; sin = '0; cos = '0;
        @(posedge clk);
        #1;
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_in_ready", longint'(in_ready), 1);
        chk("rst_alpha", longint'(alpha), 0);
        chk("rst_beta", longint'(beta), 0);
        chk("rst_out_tag", longint'(out_tag), 0);
        chk("rst_sat", longint'(sat), 0);
        cycle();
        rstb = 1'b1;
        cycle();

        // Nominal
        send(2'd1, -2, 4096, 23157, 23173);
        wait_out(lat);
        chk("nom_latency", lat, 3);
        chk("nom_alpha", longint'(alpha), -2896);
        chk("nom_beta", longint'(beta), 2895);
        chk("nom_tag", longint'(out_tag), 1);
        chk("nom_sat", longint'(sat), 0);
        cycle();

        // Saturation / wrap
        send(2'd2, 262143, 262143, 32767, 32767);
        wait_out(lat);
        chk("sat_latency", lat, 3);
        chk("sat_alpha", longint'(alpha), 0);
`ifdef INV_PARK_SAT_EN
        chk("sat_beta", longint'(beta), 262143);
        chk("sat_flag", longint'(sat), 1);
`else
        chk("sat_beta", longint'(beta), -18);
        chk("sat_flag", longint'(sat), 0);
`endif
        cycle();

        // Rounding boundary
        send(2'd0, 1, 0, 0, 16384);
        wait_out(lat);
        chk("rnd_half_up", longint'(alpha), 1);
        cycle();
        send(2'd3, -1, 0, 0, 16384);
        wait_out(lat);
        chk("rnd_neg_half", longint'(alpha), 0);
        cycle();

        // Streaming: 8 back-to-back samples
        n0 = n_out;
        first_out = -1;
        for (int i = 0; i < 8; i++)
            send(TW'(i % 4), rnd_data(), rnd_data(), rnd_trig(), rnd_trig());
        repeat (6) cycle();
        chk("stream_count", n_out - n0, 8);
        chk("stream_span", last_out - first_out + 1, 8);

        // Backpressure with random out_ready
        n0   = n_out;
        sent = 0;
        for (int t = 0; t < 300 && (sent < 6 || sb.size() != 0); t++) begin
            out_ready = 1'($urandom_range(0, 1));
            if (sent < 6) begin
                in_valid = 1'b1;
                in_tag   = TW'(sent % 4);
                D        = W'(rnd_data());
                Q        = W'(rnd_data());
                sin      = W'(rnd_trig());
                cos      = W'(rnd_trig());
            end else begin
                in_valid = 1'b0;
            end
            cycle();
            if (last_in_x) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_sent", sent, 6);
        chk("bp_count", n_out - n0, 6);
        chk("bp_drained", longint'(sb.size()), 0);

        // Reset with three samples in flight
        for (int i = 0; i < 3; i++)
            send(TW'(i + 1), rnd_data(), rnd_data(), rnd_trig(), rnd_trig());
        rstb = 1'b0;
        #1;
        chk("mid_rst_out_valid", longint'(out_valid), 0);
        chk("mid_rst_alpha", longint'(alpha), 0);
        chk("mid_rst_beta", longint'(beta), 0);
        chk("mid_rst_tag", longint'(out_tag), 0);
        chk("mid_rst_sat", longint'(sat), 0);
        chk("mid_rst_in_ready", longint'(in_ready), 1);
        sb.delete();
        n0 = n_out;
        cycle();
        cycle();
        rstb = 1'b1;
        repeat (5) cycle();
        chk("post_rst_no_output", n_out - n0, 0);
        send(2'd2, 1000, -2000, 12000, -30000);
        wait_out(lat);
        chk("post_rst_latency", lat, 3);
        cycle();
        repeat (3) cycle();

        chk("sb_empty_end", longint'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
